// File: rtl/tx_dma_chan_ctrl_pkg.sv
// Shared types and register layout for the TX DMA channel controller.
// State encoding, MI register offsets and STATUS bit positions.
package tx_dma_chan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } chan_state_e;

  localparam logic [3:0] CTRL_OFF = 4'h0;
  localparam logic [3:0] STAT_OFF = 4'h4;

  localparam int STAT_ST_LSB  = 0;
  localparam int STAT_ERR_BIT = 8;
  localparam int STAT_CNT_LSB = 16;
  localparam int STAT_CNT_W   = 16;

  function automatic logic [31:0] pack_status(
    input logic [1:0]  st,
    input logic        err,
    input logic [15:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_ST_LSB +: 2]           = st;
    s[STAT_ERR_BIT]               = err;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/tx_dma_chan_fsm.sv
// One DMA channel: CONTROL bit, start/stop FSM, outstanding-packet counter, error flag.
// In: ctrl_wr/ctrl_val, err_clr, acc, sent. Out: ctrl, state, active, err, cnt.
module tx_dma_chan_fsm
  import tx_dma_chan_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ctrl_wr,
  input  logic             ctrl_val,
  input  logic             err_clr,
  input  logic             acc,
  input  logic             sent,
  output logic             ctrl,
  output logic [1:0]       state,
  output logic             active,
  output logic             err,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chan_state_e      st_q;
  chan_state_e      st_d;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;

  assign state = st_q;

  // FSM follows the CONTROL register, so a write lands one edge later.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_STOPPED:  if (ctrl)         st_d = ST_RUNNING;
      ST_RUNNING:  if (!ctrl)        st_d = ST_STOPPING;
      ST_STOPPING: if (cnt == '0)    st_d = ST_STOPPED;
      default:                       st_d = ST_STOPPED;
    endcase
  end

  // A new underflow wins over a clear in the same cycle.
  always_comb begin
    cnt_d = cnt;
    err_d = err & ~err_clr;
    if (acc && !sent) begin
      if (cnt != CNT_MAX) cnt_d = cnt + CNT_W'(1);
    end else if (sent && !acc) begin
      if (cnt == '0) err_d = 1'b1;
      else           cnt_d = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q   <= ST_STOPPED;
      active <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
      ctrl   <= 1'b0;
    end else begin
      st_q   <= st_d;
      active <= (st_d == ST_RUNNING);
      cnt    <= cnt_d;
      err    <= err_d;
      if (ctrl_wr) ctrl <= ctrl_val;
    end
  end

endmodule

// File: rtl/tx_dma_chan_ctrl.sv
// TX DMA per-channel start/stop controller: MI decode, read mux, channel array.
// MI slave in/out, packet accept/sent events in, CHAN_ACTIVE vector out.
module tx_dma_chan_ctrl
  import tx_dma_chan_ctrl_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int MI_WIDTH       = 32,
  parameter int PKT_CNTR_WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [MI_WIDTH-1:0]         MI_ADDR,
  input  logic [MI_WIDTH-1:0]         MI_DWR,
  input  logic [MI_WIDTH/8-1:0]       MI_BE,
  input  logic                        MI_RD,
  input  logic                        MI_WR,
  output logic [MI_WIDTH-1:0]         MI_DRD,
  output logic                        MI_ARDY,
  output logic                        MI_DRDY,
  input  logic                        PKT_ACC_VLD,
  input  logic [$clog2(CHANNELS)-1:0] PKT_ACC_CHAN,
  input  logic                        PKT_SENT_VLD,
  input  logic [$clog2(CHANNELS)-1:0] PKT_SENT_CHAN,
  output logic [CHANNELS-1:0]         CHAN_ACTIVE
);

  localparam int CW = $clog2(CHANNELS);

  logic [CW-1:0]             mi_chan;
  logic [3:0]                mi_off;
  logic                      wr_en;
  logic [CHANNELS-1:0]       ctrl_wr;
  logic [CHANNELS-1:0]       err_clr;
  logic [CHANNELS-1:0]       acc;
  logic [CHANNELS-1:0]       sent;
  logic [CHANNELS-1:0]       ctrl;
  logic [CHANNELS-1:0]       err;
  logic [1:0]                st  [CHANNELS];
  logic [PKT_CNTR_WIDTH-1:0] cnt [CHANNELS];
  logic [31:0]               rd_val;
  logic                      unused_bits;

  assign mi_chan     = MI_ADDR[CW+3:4];
  assign mi_off      = MI_ADDR[3:0];
  assign wr_en       = MI_WR & MI_BE[0];
  assign MI_ARDY     = MI_RD | MI_WR;
  assign unused_bits = ^{MI_ADDR, MI_DWR, MI_BE};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic sel;
    assign sel        = wr_en && (mi_chan == CW'(c));
    assign ctrl_wr[c] = sel && (mi_off == CTRL_OFF);
    assign err_clr[c] = sel && (mi_off == STAT_OFF) &&
                        MI_DWR[STAT_ERR_BIT];
    assign acc[c]     = PKT_ACC_VLD && (PKT_ACC_CHAN == CW'(c));
    assign sent[c]    = PKT_SENT_VLD && (PKT_SENT_CHAN == CW'(c));

    tx_dma_chan_fsm #(
      .CNT_W (PKT_CNTR_WIDTH)
    ) u_chan (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .ctrl_wr  (ctrl_wr[c]),
      .ctrl_val (MI_DWR[0]),
      .err_clr  (err_clr[c]),
      .acc      (acc[c]),
      .sent     (sent[c]),
      .ctrl     (ctrl[c]),
      .state    (st[c]),
      .active   (CHAN_ACTIVE[c]),
      .err      (err[c]),
      .cnt      (cnt[c])
    );
  end

  // Reads sample pre-edge state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_val = '0;
    case (mi_off)
      CTRL_OFF: rd_val[0] = ctrl[mi_chan];
      STAT_OFF: rd_val = pack_status(st[mi_chan], err[mi_chan],
                                     16'(cnt[mi_chan]));
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MI_DRD  <= '0;
      MI_DRDY <= 1'b0;
    end else begin
      MI_DRDY <= MI_RD;
      if (MI_RD) MI_DRD <= MI_WIDTH'(rd_val);
    end
  end

endmodule

// File: tb/tb_tx_dma_chan_ctrl.sv
// Self-checking bench for tx_dma_chan_ctrl.
// Read expectations go to a scoreboard queue and are checked on MI_DRDY.
module tb_tx_dma_chan_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] MI_ADDR = '0;
  logic [31:0] MI_DWR = '0;
  logic [3:0]  MI_BE = '0;
  logic        MI_RD = 1'b0;
  logic        MI_WR = 1'b0;
  logic [31:0] MI_DRD;
  logic        MI_ARDY;
  logic        MI_DRDY;
  logic        PKT_ACC_VLD = 1'b0;
  logic [2:0]  PKT_ACC_CHAN = '0;
  logic        PKT_SENT_VLD = 1'b0;
  logic [2:0]  PKT_SENT_CHAN = '0;
  logic [7:0]  CHAN_ACTIVE;

  rd_exp_t sb_q[$];
  int      total = 0;
  int      bad = 0;

  always #5 CLK = ~CLK;

  tx_dma_chan_ctrl #(
    .CHANNELS       (8),
    .MI_WIDTH       (32),
    .PKT_CNTR_WIDTH (4)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .MI_ADDR       (MI_ADDR),
    .MI_DWR        (MI_DWR),
    .MI_BE         (MI_BE),
    .MI_RD         (MI_RD),
    .MI_WR         (MI_WR),
    .MI_DRD        (MI_DRD),
    .MI_ARDY       (MI_ARDY),
    .MI_DRDY       (MI_DRDY),
    .PKT_ACC_VLD   (PKT_ACC_VLD),
    .PKT_ACC_CHAN  (PKT_ACC_CHAN),
    .PKT_SENT_VLD  (PKT_SENT_VLD),
    .PKT_SENT_CHAN (PKT_SENT_CHAN),
    .CHAN_ACTIVE   (CHAN_ACTIVE)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && MI_DRDY) begin
      if (sb_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("rd@%h", e.addr), MI_DRD, e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    MI_ADDR = a;
    MI_RD   = 1'b1;
    sb_q.push_back('{addr: a, exp: e});
    @(posedge CLK);
    #1;
    MI_RD = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    MI_ADDR = a;
    MI_DWR  = d;
    MI_BE   = be;
    MI_WR   = 1'b1;
    @(posedge CLK);
    #1;
    MI_WR = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e);
    MI_ADDR = a;
    MI_DWR  = d;
    MI_BE   = 4'hf;
    MI_WR   = 1'b1;
    MI_RD   = 1'b1;
    sb_q.push_back('{addr: a, exp: e});
    @(posedge CLK);
    #1;
    MI_WR = 1'b0;
    MI_RD = 1'b0;
  endtask

  task automatic acc(input logic [2:0] ch);
    PKT_ACC_VLD  = 1'b1;
    PKT_ACC_CHAN = ch;
    @(posedge CLK);
    #1;
    PKT_ACC_VLD = 1'b0;
  endtask

  task automatic snd(input logic [2:0] ch);
    PKT_SENT_VLD  = 1'b1;
    PKT_SENT_CHAN = ch;
    @(posedge CLK);
    #1;
    PKT_SENT_VLD = 1'b0;
  endtask

  initial begin
    cyc(2);
    RESET_N = 1'b1;
    cyc(1);

    // reset state
    chk("rst_active", 32'(CHAN_ACTIVE), 32'h0);
    chk("rst_drdy", 32'(MI_DRDY), 32'h0);
    for (int c = 0; c < 8; c++) rd(32'(c * 16 + 4), 32'h0);
    chk("ardy_rd", 32'(MI_ARDY), 32'h0);

    // start ch3
    wr(32'h30, 32'h1, 4'hf);
    chk("ch3_act_pre", 32'(CHAN_ACTIVE), 32'h00);
    cyc(1);
    chk("ch3_act", 32'(CHAN_ACTIVE), 32'h08);
    rd(32'h34, 32'h0000_0001);
    rd(32'h30, 32'h0000_0001);

    // traffic then stop, then drain
    repeat (5) acc(3'd3);
    repeat (2) snd(3'd3);
    wr(32'h30, 32'h0, 4'hf);
    cyc(1);
    chk("ch3_stopping_act", 32'(CHAN_ACTIVE), 32'h00);
    rd(32'h34, 32'h0003_0002);
    repeat (3) snd(3'd3);
    cyc(1);
    rd(32'h34, 32'h0000_0000);
    chk("ch3_stopped_act", 32'(CHAN_ACTIVE), 32'h00);

    // simultaneous accept+send on ch1
    PKT_ACC_VLD   = 1'b1;
    PKT_ACC_CHAN  = 3'd1;
    PKT_SENT_VLD  = 1'b1;
    PKT_SENT_CHAN = 3'd1;
    cyc(10);
    PKT_ACC_VLD  = 1'b0;
    PKT_SENT_VLD = 1'b0;
    rd(32'h14, 32'h0);

    // underflow on idle ch2, then clear
    snd(3'd2);
    rd(32'h24, 32'h0000_0100);
    wr(32'h24, 32'h0000_0100, 4'hf);
    rd(32'h24, 32'h0);

    // BE[0]=0 write ignored, unmapped offsets
    wr(32'h50, 32'h1, 4'he);
    cyc(2);
    chk("be0_ignored_act", 32'(CHAN_ACTIVE), 32'h00);
    rd(32'h50, 32'h0);
    wr(32'h58, 32'hffff_ffff, 4'hf);
    rd(32'h58, 32'h0);

    // saturation while stopped
    repeat (20) acc(3'd6);
    rd(32'h64, 32'h000F_0000);
    snd(3'd6);
    rd(32'h64, 32'h000E_0000);

    // stop with empty counter: STOPPING exactly one cycle
    wr(32'h40, 32'h1, 4'hf);
    cyc(1);
    chk("ch4_act", 32'(CHAN_ACTIVE), 32'h10);
    wr(32'h40, 32'h0, 4'hf);
    rd(32'h44, 32'h1);
    rd(32'h44, 32'h2);
    rd(32'h44, 32'h0);

    // read+write same cycle returns pre-write value
    rdwr(32'h70, 32'h1, 32'h0);
    rd(32'h70, 32'h1);
    chk("ch7_act", 32'(CHAN_ACTIVE), 32'h80);
    wr(32'h70, 32'h0, 4'hf);
    cyc(3);
    chk("ch7_off", 32'(CHAN_ACTIVE), 32'h00);

    // restart during STOPPING
    wr(32'h00, 32'h1, 4'hf);
    cyc(1);
    chk("ch0_act", 32'(CHAN_ACTIVE), 32'h01);
    repeat (2) acc(3'd0);
    wr(32'h00, 32'h0, 4'hf);
    cyc(1);
    rd(32'h04, 32'h0002_0002);
    wr(32'h00, 32'h1, 4'hf);
    cyc(1);
    rd(32'h04, 32'h0002_0002);
    chk("ch0_restart_wait", 32'(CHAN_ACTIVE), 32'h00);
    repeat (2) snd(3'd0);
    rd(32'h04, 32'h0000_0002);
    chk("ch0_stopped_act", 32'(CHAN_ACTIVE), 32'h00);
    rd(32'h04, 32'h0000_0000);
    chk("ch0_rerun_act", 32'(CHAN_ACTIVE), 32'h01);
    rd(32'h04, 32'h0000_0001);

    // reset mid-drain
    repeat (3) acc(3'd0);
    wr(32'h00, 32'h0, 4'hf);
    cyc(1);
    rd(32'h04, 32'h0003_0002);
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_active", 32'(CHAN_ACTIVE), 32'h0);
    chk("rst_mid_drdy", 32'(MI_DRDY), 32'h0);
    chk("rst_mid_drd", MI_DRD, 32'h0);
    #3;
    RESET_N = 1'b1;
    cyc(2);
    rd(32'h04, 32'h0);
    rd(32'h00, 32'h0);
    rd(32'h64, 32'h0);
    chk("post_rst_active", 32'(CHAN_ACTIVE), 32'h0);

    cyc(3);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_dma_chan_ctrl.md
# tx_dma_chan_ctrl

Per-channel start/stop controller for the Calypte TX DMA datapath. Software starts or stops each channel through MI registers. The block tracks packets accepted from the PCIe CQ side and packets delivered on the user TX MFB. A channel is reported stopped only after every packet it accepted has drained. The block sits beside the TX DMA core on the MI configuration bus, and its `CHAN_ACTIVE` vector gates CQ write acceptance in the datapath.

## Interface
Parameters:
- `CHANNELS`, 8: number of DMA channels; power of two, ≥ 2.
- `MI_WIDTH`, 32: MI data and address width.
- `PKT_CNTR_WIDTH`, 16: width of each per-channel outstanding-packet counter.

Ports (one clock; reset asynchronous, active-low):
- `CLK` in, 1: clock.
- `RESET_N` in, 1: asynchronous active-low reset.
- `MI_ADDR` in, `MI_WIDTH`: byte address.
- `MI_DWR` in, `MI_WIDTH`: write data.
- `MI_BE` in, `MI_WIDTH/8`: byte enables.
- `MI_RD` / `MI_WR` in, 1: read / write request.
- `MI_DRD` out, `MI_WIDTH`: read data.
- `MI_ARDY` out, 1: address ready.
- `MI_DRDY` out, 1: read data valid.
- `PKT_ACC_VLD` in, 1: one packet accepted into the TX buffer.
- `PKT_ACC_CHAN` in, `log2(CHANNELS)`: channel of the accepted packet.
- `PKT_SENT_VLD` in, 1: one packet fully transmitted on user TX (EOF handshake).
- `PKT_SENT_CHAN` in, `log2(CHANNELS)`: channel of the sent packet.
- `CHAN_ACTIVE` out, `CHANNELS`: bit c = 1 while channel c is RUNNING.

## Operation
- Register map: channel c at base `c*0x10`. Channel field = `MI_ADDR[log2(CHANNELS)+3:4]`.
  - `0x0` CONTROL (RW): bit0 is the requested state (1 = start, 0 = stop). Reads return the last written value.
  - `0x4` STATUS (RO): bits[1:0] = state; bit8 = sticky underflow error; bits[31:16] = outstanding count (zero-extended or truncated to 16 bits).
  - Write 1 to STATUS bit8 to clear the error.
  - Any other offset reads 0; writes to it are ignored.
- Writes take effect only when `MI_BE[0]=1`.
- Per-channel FSM states: STOPPED=0, RUNNING=1, STOPPING=2.
  - STOPPED → RUNNING on a CONTROL write with bit0=1.
  - RUNNING → STOPPING on a CONTROL write with bit0=0.
  - STOPPING → STOPPED in the cycle after the counter reads 0 while in STOPPING.
  - A stop while STOPPED, or a start while RUNNING, has no effect.
  - A start written during STOPPING updates CONTROL but changes no state. Once STOPPED is reached, the FSM moves to RUNNING on the next cycle if CONTROL bit0=1.
- Outstanding counter, per channel:
  - +1 on `PKT_ACC_VLD` for that channel; -1 on `PKT_SENT_VLD` for that channel.
  - Both in the same cycle on the same channel: unchanged.
  - Counts in every state, because in-flight accepts can arrive after a stop.
  - Saturates at `2^PKT_CNTR_WIDTH-1`.
  - A decrement at 0 holds 0 and sets the sticky error bit.
- `CHAN_ACTIVE[c]` is driven from a register: 1 exactly while the state is RUNNING.

## Timing
- Reset values: all states STOPPED, CONTROL 0, counters 0, error bits 0, `CHAN_ACTIVE`=0, `MI_DRD`=0, `MI_DRDY`=0. Reset asserted mid-drain discards all counts immediately.
- `MI_ARDY` = `MI_RD | MI_WR`, combinational; there is no wait state.
- Read latency is 1 cycle: `MI_DRDY` and a registered `MI_DRD` follow each accepted `MI_RD`. `MI_DRDY` deasserts the next cycle unless another read was accepted.
- A CONTROL write at edge N changes the state at edge N+1. `CHAN_ACTIVE` changes at that same edge N+1.
- Counter updates are visible on STATUS reads issued 1 cycle after the event.
- STOP with counter already 0: STOPPING for exactly 1 cycle, then STOPPED.
- `MI_RD` and `MI_WR` asserted together: the write is performed; the read returns the pre-write value.

## Structure
- Package `tx_dma_chan_ctrl_pkg` holds:
  - a state enum (2 bits);
  - register offset constants `CTRL_OFF=0x0`, `STAT_OFF=0x4`;
  - the status bit positions.
- Sub-module `tx_dma_chan_fsm` contains one channel's FSM, counter and error bit. It is instantiated `CHANNELS` times.
- The top level holds the MI decode and the read mux.

## Test plan
- After reset, read STATUS of every channel → 0 for each, `CHAN_ACTIVE=0x00`.
- Write CONTROL ch3 = 1 → `CHAN_ACTIVE=0x08` one cycle later; STATUS ch3 reads 0x00000001.
- Ch3 RUNNING, 5 accepts, 2 sends, then stop → STATUS = 0x00030002. Then 3 sends → STATUS = 0x00000000 and `CHAN_ACTIVE[3]=0`.
- Accept and send on ch1 in the same cycle, 10 consecutive cycles → count stays 0, no error.
- Send on idle ch2 → STATUS ch2 bit8 = 1 and count 0. Write STATUS ch2 = 0x100 → bit8 clears.
- Ch0 STOPPING with count 2, write start, drain 2 → STOPPED for 1 cycle, then RUNNING (`CHAN_ACTIVE[0]=1`). Assert `RESET_N`=0 mid-drain → all outputs return to their reset values at once.
